ladybird_mmu_spec: RTL and testbench

LADYBIRD_MMU_SPEC -- requirements
Module: ladybird_mmu

---
 rtl/ladybird_mmu_spec.sv | 200 ++++++++++++++++++++
 tb/tb_ladybird_mmu_spec.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ladybird_mmu_spec.sv
// Fetch and load/store bus adapter: one outstanding transaction per port.
// The fetch path and the data path run independently of each other.
module ladybird_mmu_spec #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              nrst,
   // fetch request
   input  logic [XLEN-1:0]   pc,
   input  logic              pc_valid,
   output logic              pc_ready,
   output logic [31:0]       inst,
   output logic              inst_valid,
   // data request / response
   input  logic              i_valid,
   output logic              i_ready,
   input  logic [XLEN-1:0]   i_addr,
   input  logic [XLEN-1:0]   i_data,
   input  logic              i_we,
   input  logic [2:0]        i_funct,
   output logic              o_valid,
   input  logic              o_ready,
   output logic [XLEN-1:0]   o_data,
   // instruction bus
   output logic              i_bus_req_valid,
   output logic [XLEN-1:0]   i_bus_addr,
   output logic              i_bus_we,
   output logic [XLEN-1:0]   i_bus_wdata,
   output logic [3:0]        i_bus_strb,
   input  logic              i_bus_req_ready,
   input  logic              i_bus_resp_valid,
   input  logic [XLEN-1:0]   i_bus_rdata,
   // data bus
   output logic              d_bus_req_valid,
   output logic [XLEN-1:0]   d_bus_addr,
   output logic              d_bus_we,
   output logic [XLEN-1:0]   d_bus_wdata,
   output logic [3:0]        d_bus_strb,
   input  logic              d_bus_req_ready,
   input  logic              d_bus_resp_valid,
   input  logic [XLEN-1:0]   d_bus_rdata,
   // FSM state observation
   output logic [1:0]        fetch_state_dbg,
   output logic [1:0]        data_state_dbg
);

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both 1; valid, once raised, is held with stable fields until ready.

   typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT} fetch_state_t;
   typedef enum logic [1:0] {D_IDLE, D_REQ, D_WAIT, D_RESP} data_state_t;

   fetch_state_t f_state, f_next;
   data_state_t  d_state, d_next;

   logic [2:0]      d_funct_q;
   logic [1:0]      d_lane_q;
   logic [3:0]      st_strb;
   logic [XLEN-1:0] st_wdata;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] ld_data;
   logic            unused_pc_bits;

   assign unused_pc_bits = &{1'b0, pc[1:0]};

   // ---------------- fetch path ----------------
   always_comb begin
      f_next          = f_state;
      pc_ready        = 1'b0;
      i_bus_req_valid = 1'b0;
      i_bus_we        = 1'b0;
      i_bus_wdata     = '0;
      i_bus_strb      = 4'b0000;
      case (f_state)
         F_IDLE: begin
            pc_ready = 1'b1;
            if (pc_valid) f_next = F_REQ;
         end
         F_REQ: begin
            i_bus_req_valid = 1'b1;
            i_bus_strb      = 4'b1111;
            if (i_bus_req_ready) f_next = F_WAIT;
         end
         F_WAIT: begin
            if (i_bus_resp_valid) f_next = F_IDLE;
         end
         default: f_next = F_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         f_state    <= F_IDLE;
         i_bus_addr <= '0;
         inst       <= '0;
         inst_valid <= 1'b0;
      end else begin
         f_state    <= f_next;
         inst_valid <= 1'b0;
         if (f_state == F_IDLE && pc_valid)
            i_bus_addr <= {pc[XLEN-1:2], 2'b00};
         if (f_state == F_WAIT && i_bus_resp_valid) begin
            inst       <= i_bus_rdata[31:0];
            inst_valid <= 1'b1;
         end
      end
   end

   // ---------------- data path ----------------
   always_comb begin
      st_strb  = 4'b1111;
      st_wdata = i_data;
      case (i_funct)
         3'b000: begin
            st_strb  = 4'b0001 << i_addr[1:0];
            st_wdata = {(XLEN/8){i_data[7:0]}};
         end
         3'b001: begin
            st_strb  = i_addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {(XLEN/16){i_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Lane selection uses the request's latched address bits, not the bus.
   always_comb begin
      ld_byte = 8'h00;
      case (d_lane_q)
         2'd0: ld_byte = d_bus_rdata[7:0];
         2'd1: ld_byte = d_bus_rdata[15:8];
         2'd2: ld_byte = d_bus_rdata[23:16];
         2'd3: ld_byte = d_bus_rdata[31:24];
         default: ;
      endcase
      ld_half = d_lane_q[1] ? d_bus_rdata[31:16] : d_bus_rdata[15:0];
      case (d_funct_q)
         3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
         3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
         3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
         default: ld_data = d_bus_rdata;
      endcase
   end

   always_comb begin
      d_next          = d_state;
      i_ready         = 1'b0;
      o_valid         = 1'b0;
      d_bus_req_valid = 1'b0;
      case (d_state)
         D_IDLE: begin
            i_ready = 1'b1;
            if (i_valid) d_next = D_REQ;
         end
         D_REQ: begin
            d_bus_req_valid = 1'b1;
            if (d_bus_req_ready) d_next = D_WAIT;
         end
         D_WAIT: begin
            if (d_bus_resp_valid) d_next = D_RESP;
         end
         D_RESP: begin
            o_valid = 1'b1;
            if (o_ready) d_next = D_IDLE;
         end
         default: d_next = D_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         d_state     <= D_IDLE;
         d_bus_addr  <= '0;
         d_bus_we    <= 1'b0;
         d_bus_wdata <= '0;
         d_bus_strb  <= 4'b0000;
         d_funct_q   <= 3'b000;
         d_lane_q    <= 2'b00;
         o_data      <= '0;
      end else begin
         d_state <= d_next;
         if (d_state == D_IDLE && i_valid) begin
            d_bus_addr  <= {i_addr[XLEN-1:2], 2'b00};
            d_bus_we    <= i_we;
            d_bus_wdata <= st_wdata;
            d_bus_strb  <= st_strb;
            d_funct_q   <= i_funct;
            d_lane_q    <= i_addr[1:0];
         end
         if (d_state == D_WAIT && d_bus_resp_valid)
            o_data <= d_bus_we ? '0 : ld_data;
      end
   end

   assign fetch_state_dbg = f_state;
   assign data_state_dbg  = d_state;

endmodule

// File: tb/tb_ladybird_mmu_spec.sv
// Directed bench for ladybird_mmu_spec: fetch, loads, stores, backpressure
// and reset-abort scenarios with hand-computed expectations.
module tb_ladybird_mmu_spec;

   logic        clk = 1'b0;
   logic        nrst;
   logic [31:0] pc;
   logic        pc_valid;
   logic        pc_ready;
   logic [31:0] inst;
   logic        inst_valid;
   logic        i_valid;
   logic        i_ready;
   logic [31:0] i_addr;
   logic [31:0] i_data;
   logic        i_we;
   logic [2:0]  i_funct;
   logic        o_valid;
   logic        o_ready;
   logic [31:0] o_data;
   logic        i_bus_req_valid;
   logic [31:0] i_bus_addr;
   logic        i_bus_we;
   logic [31:0] i_bus_wdata;
   logic [3:0]  i_bus_strb;
   logic        i_bus_req_ready;
   logic        i_bus_resp_valid;
   logic [31:0] i_bus_rdata;
   logic        d_bus_req_valid;
   logic [31:0] d_bus_addr;
   logic        d_bus_we;
   logic [31:0] d_bus_wdata;
   logic [3:0]  d_bus_strb;
   logic        d_bus_req_ready;
   logic        d_bus_resp_valid;
   logic [31:0] d_bus_rdata;
   logic [1:0]  fetch_state_dbg;
   logic [1:0]  data_state_dbg;

   int n_cmp = 0;
   int n_mis = 0;

   ladybird_mmu_spec #(.XLEN(32)) dut (
      .clk(clk), .nrst(nrst),
      .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
      .inst(inst), .inst_valid(inst_valid),
      .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_data(i_data),
      .i_we(i_we), .i_funct(i_funct),
      .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
      .i_bus_req_valid(i_bus_req_valid), .i_bus_addr(i_bus_addr), .i_bus_we(i_bus_we),
      .i_bus_wdata(i_bus_wdata), .i_bus_strb(i_bus_strb), .i_bus_req_ready(i_bus_req_ready),
      .i_bus_resp_valid(i_bus_resp_valid), .i_bus_rdata(i_bus_rdata),
      .d_bus_req_valid(d_bus_req_valid), .d_bus_addr(d_bus_addr), .d_bus_we(d_bus_we),
      .d_bus_wdata(d_bus_wdata), .d_bus_strb(d_bus_strb), .d_bus_req_ready(d_bus_req_ready),
      .d_bus_resp_valid(d_bus_resp_valid), .d_bus_rdata(d_bus_rdata),
      .fetch_state_dbg(fetch_state_dbg), .data_state_dbg(data_state_dbg)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One complete data transaction with the request inputs scrambled after acceptance.
   task automatic data_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic we, input logic [2:0] funct, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input logic [31:0] exp_o,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
      chk({tag, "_i_ready_idle"}, i_ready, 1);
      i_addr = addr; i_data = wdata; i_we = we; i_funct = funct; i_valid = 1'b1;
      tick();
      i_valid = 1'b0; i_addr = 32'hFFFF_FFFF; i_data = 32'h0; i_we = ~we; i_funct = 3'b111;
      chk({tag, "_req_valid"}, d_bus_req_valid, 1);
      chk({tag, "_addr"}, d_bus_addr, exp_addr);
      chk({tag, "_we"}, d_bus_we, we);
      if (we) begin
         chk({tag, "_strb"}, d_bus_strb, exp_strb);
         chk({tag, "_wdata"}, d_bus_wdata, exp_wdata);
      end
      d_bus_req_ready = 1'b1;
      tick();
      d_bus_req_ready = 1'b0;
      chk({tag, "_req_dropped"}, d_bus_req_valid, 0);
      d_bus_resp_valid = 1'b1; d_bus_rdata = rdata;
      tick();
      d_bus_resp_valid = 1'b0; d_bus_rdata = 32'h0;
      chk({tag, "_o_valid"}, o_valid, 1);
      chk({tag, "_o_data"}, o_data, exp_o);
      chk({tag, "_i_ready_pending"}, i_ready, 0);
      tick();
      chk({tag, "_o_valid_held"}, o_valid, 1);
      chk({tag, "_o_data_held"}, o_data, exp_o);
      o_ready = 1'b1;
      tick();
      o_ready = 1'b0;
      chk({tag, "_o_valid_done"}, o_valid, 0);
      chk({tag, "_i_ready_done"}, i_ready, 1);
   endtask

   initial begin
      nrst = 1'b0;
      pc = '0; pc_valid = 1'b0;
      i_valid = 1'b0; i_addr = '0; i_data = '0; i_we = 1'b0; i_funct = 3'b000;
      o_ready = 1'b0;
      i_bus_req_ready = 1'b0; i_bus_resp_valid = 1'b0; i_bus_rdata = '0;
      d_bus_req_ready = 1'b0; d_bus_resp_valid = 1'b0; d_bus_rdata = '0;

      // reset
      tick(); tick();
      chk("rst_i_bus_req_valid", i_bus_req_valid, 0);
      chk("rst_d_bus_req_valid", d_bus_req_valid, 0);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_o_valid", o_valid, 0);
      chk("rst_inst", inst, 0);
      chk("rst_o_data", o_data, 0);
      chk("rst_i_bus_strb", i_bus_strb, 0);
      chk("rst_d_bus_strb", d_bus_strb, 0);
      chk("rst_i_bus_addr", i_bus_addr, 0);
      chk("rst_d_bus_addr", d_bus_addr, 0);
      nrst = 1'b1;
      tick();
      chk("rel_pc_ready", pc_ready, 1);
      chk("rel_i_ready", i_ready, 1);

      // fetch pc=0x100
      pc = 32'h100; pc_valid = 1'b1;
      tick();
      pc_valid = 1'b0; pc = 32'hDEAD_BEEF;
      chk("f_req_valid", i_bus_req_valid, 1);
      chk("f_addr", i_bus_addr, 32'h100);
      chk("f_we", i_bus_we, 0);
      chk("f_strb", i_bus_strb, 4'b1111);
      chk("f_pc_ready_busy", pc_ready, 0);
      i_bus_req_ready = 1'b1;
      tick();
      i_bus_req_ready = 1'b0;
      chk("f_req_dropped", i_bus_req_valid, 0);
      chk("f_addr_latched", i_bus_addr, 32'h100);
      i_bus_resp_valid = 1'b1; i_bus_rdata = 32'h0050_0093;
      tick();
      i_bus_resp_valid = 1'b0; i_bus_rdata = 32'h0;
      chk("f_inst_valid", inst_valid, 1);
      chk("f_inst", inst, 32'h0050_0093);
      chk("f_pc_ready_idle", pc_ready, 1);
      tick();
      chk("f_inst_valid_pulse", inst_valid, 0);

      // stray fetch response while idle
      i_bus_resp_valid = 1'b1; i_bus_rdata = 32'hDEAD_BEEF;
      tick();
      i_bus_resp_valid = 1'b0; i_bus_rdata = 32'h0;
      chk("stray_inst_valid", inst_valid, 0);
      chk("stray_inst", inst, 32'h0050_0093);
      chk("stray_pc_ready", pc_ready, 1);

      // loads and stores
      data_txn("lb",    32'h203, 32'h0, 1'b0, 3'b000, 32'h8011_2233, 32'h200, 32'hFFFF_FF80, 4'h0, 32'h0);
      data_txn("lhu",   32'h202, 32'h0, 1'b0, 3'b101, 32'h8001_ABCD, 32'h200, 32'h0000_8001, 4'h0, 32'h0);
      data_txn("sb",    32'h301, 32'h0000_00A5, 1'b1, 3'b000, 32'h1234_5678, 32'h300, 32'h0, 4'b0010, 32'hA5A5_A5A5);
      data_txn("lh",    32'h200, 32'h0, 1'b0, 3'b001, 32'h1234_8765, 32'h200, 32'hFFFF_8765, 4'h0, 32'h0);
      data_txn("lbu",   32'h201, 32'h0, 1'b0, 3'b100, 32'h1234_9A78, 32'h200, 32'h0000_009A, 4'h0, 32'h0);
      data_txn("lw",    32'h20F, 32'h0, 1'b0, 3'b010, 32'hCAFE_BABE, 32'h20C, 32'hCAFE_BABE, 4'h0, 32'h0);
      data_txn("sh",    32'h302, 32'h1234_BEEF, 1'b1, 3'b001, 32'h0, 32'h300, 32'h0, 4'b1100, 32'hBEEF_BEEF);
      data_txn("sh_lo", 32'h301, 32'h0000_CAFE, 1'b1, 3'b001, 32'h0, 32'h300, 32'h0, 4'b0011, 32'hCAFE_CAFE);
      data_txn("sw",    32'h304, 32'h1122_3344, 1'b1, 3'b010, 32'h0, 32'h304, 32'h0, 4'b1111, 32'h1122_3344);
      data_txn("s_f7",  32'h307, 32'h5566_7788, 1'b1, 3'b111, 32'h0, 32'h304, 32'h0, 4'b1111, 32'h5566_7788);
      data_txn("l_f3",  32'h401, 32'h0, 1'b0, 3'b011, 32'h89AB_CDEF, 32'h400, 32'h89AB_CDEF, 4'h0, 32'h0);
      data_txn("lh_mis",32'h203, 32'h0, 1'b0, 3'b001, 32'hFEDC_0000, 32'h200, 32'hFFFF_FEDC, 4'h0, 32'h0);

      // data backpressure with a concurrent fetch
      i_addr = 32'h500; i_we = 1'b0; i_funct = 3'b010; i_valid = 1'b1;
      pc = 32'h206; pc_valid = 1'b1;
      tick();
      i_valid = 1'b0; pc_valid = 1'b0; i_addr = 32'h0;
      chk("bp_a_req", d_bus_req_valid, 1);
      chk("bp_a_addr", d_bus_addr, 32'h500);
      chk("bp_a_i_ready", i_ready, 0);
      chk("bp_a_f_req", i_bus_req_valid, 1);
      chk("bp_a_f_addr", i_bus_addr, 32'h204);
      i_bus_req_ready = 1'b1;
      tick();
      i_bus_req_ready = 1'b0;
      chk("bp_b_req", d_bus_req_valid, 1);
      chk("bp_b_addr", d_bus_addr, 32'h500);
      chk("bp_b_i_ready", i_ready, 0);
      i_bus_resp_valid = 1'b1; i_bus_rdata = 32'h1234_5678;
      tick();
      i_bus_resp_valid = 1'b0; i_bus_rdata = 32'h0;
      chk("bp_c_req", d_bus_req_valid, 1);
      chk("bp_c_addr", d_bus_addr, 32'h500);
      chk("bp_c_i_ready", i_ready, 0);
      chk("bp_c_inst_valid", inst_valid, 1);
      chk("bp_c_inst", inst, 32'h1234_5678);
      tick();
      chk("bp_d_req", d_bus_req_valid, 1);
      chk("bp_d_i_ready", i_ready, 0);
      chk("bp_d_inst_valid", inst_valid, 0);
      d_bus_req_ready = 1'b1;
      tick();
      d_bus_req_ready = 1'b0;
      d_bus_resp_valid = 1'b1; d_bus_rdata = 32'h0BAD_F00D;
      tick();
      d_bus_resp_valid = 1'b0; d_bus_rdata = 32'h0;
      chk("bp_o_valid", o_valid, 1);
      chk("bp_o_data", o_data, 32'h0BAD_F00D);
      o_ready = 1'b1;
      tick();
      o_ready = 1'b0;
      chk("bp_done_i_ready", i_ready, 1);

      // reset in the middle of a load
      i_addr = 32'h600; i_we = 1'b0; i_funct = 3'b010; i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      d_bus_req_ready = 1'b1;
      tick();
      d_bus_req_ready = 1'b0;
      nrst = 1'b0;
      tick();
      nrst = 1'b1;
      chk("mr_o_valid", o_valid, 0);
      chk("mr_req_valid", d_bus_req_valid, 0);
      chk("mr_addr", d_bus_addr, 0);
      chk("mr_o_data", o_data, 0);
      tick();
      chk("mr_i_ready", i_ready, 1);
      d_bus_resp_valid = 1'b1; d_bus_rdata = 32'hFFFF_FFFF;
      tick();
      d_bus_resp_valid = 1'b0; d_bus_rdata = 32'h0;
      chk("mr_stale_o_valid", o_valid, 0);
      chk("mr_stale_i_ready", i_ready, 1);
      chk("mr_stale_o_data", o_data, 0);
      tick();
      chk("mr_stale_o_valid2", o_valid, 0);
      data_txn("post_rst_lb", 32'h700, 32'h0, 1'b0, 3'b000, 32'h0000_007F, 32'h700, 32'h0000_007F, 4'h0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
